// File: rtl/width_conv_fifo.sv
// Width-converting FIFO: packs RATIO narrow write words into one wide read word.
// Optional macro WIDTH_CONV_FIFO_OUTREG_EN adds an output register (read latency 2).
module width_conv_fifo #(
    parameter int WR_DATA_WIDTH    = 16,
    parameter int RATIO            = 8,
    parameter int RD_DEPTH_WIDTH   = 10,
    parameter int ALMOST_FULL_NUM  = 1016,
    parameter int ALMOST_EMPTY_NUM = 4
) (
    input  logic                           clk,
    input  logic                           tb_rst,
    input  logic                           wr_en,
    input  logic [WR_DATA_WIDTH-1:0]       wr_data,
    output logic                           wr_full,
    input  logic                           rd_en,
    output logic [WR_DATA_WIDTH*RATIO-1:0] rd_data,
    output logic                           rd_valid,
    output logic                           rd_empty,
    output logic [RD_DEPTH_WIDTH:0]        water_level,
    output logic                           almost_full,
    output logic                           almost_empty,
    output logic                           overflow,
    output logic                           underflow
);

    localparam int RW    = WR_DATA_WIDTH * RATIO;
    localparam int LW    = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int AW    = RD_DEPTH_WIDTH;
    localparam int CW    = RD_DEPTH_WIDTH + 1;
    localparam int DEPTH = 2 ** RD_DEPTH_WIDTH;

    localparam logic [LW-1:0] LAST_LANE = LW'(RATIO - 1);
    localparam logic [CW-1:0] FULL_LVL  = CW'(DEPTH);
    localparam logic [CW-1:0] AF_LVL    = CW'(ALMOST_FULL_NUM);
    localparam logic [CW-1:0] AE_LVL    = CW'(ALMOST_EMPTY_NUM);

    logic [RW-1:0] mem [DEPTH];
    logic [RW-1:0] packer;
    logic [RW-1:0] commit_word;
    logic [LW-1:0] lane_idx;
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [CW-1:0] level;
    logic          wr_acc;
    logic          rd_acc;
    logic          commit;
    logic [RW-1:0] rd_q;
    logic          rv_q;

    assign wr_full  = (level == FULL_LVL) && (lane_idx == LAST_LANE);
    assign rd_empty = (level == '0);
    assign wr_acc   = wr_en && !wr_full;
    assign rd_acc   = rd_en && !rd_empty;
    assign commit   = wr_acc && (lane_idx == LAST_LANE);

    assign water_level  = level;
    assign almost_full  = (level >= AF_LVL);
    assign almost_empty = (level <= AE_LVL);

    // Wide word as it will look once the incoming write fills the top lane
    always_comb begin
        commit_word = packer;
        commit_word[RW-WR_DATA_WIDTH +: WR_DATA_WIDTH] = wr_data;
    end

    // Packer lanes fill LSB first; lane index wraps on the committing write
    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            packer   <= '0;
            lane_idx <= '0;
        end else if (wr_acc) begin
            packer[lane_idx*WR_DATA_WIDTH +: WR_DATA_WIDTH] <= wr_data;
            if (lane_idx == LAST_LANE)
                lane_idx <= '0;
            else
                lane_idx <= lane_idx + LW'(1);
        end
    end

    // Storage array; no reset, contents are only reachable through the pointers
    always_ff @(posedge clk) begin
        if (commit)
            mem[wptr] <= commit_word;
    end

    // Pointers and committed-word count
    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (commit)
                wptr <= wptr + AW'(1);
            if (rd_acc)
                rptr <= rptr + AW'(1);
            unique case ({commit, rd_acc})
                2'b10:   level <= level + CW'(1);
                2'b01:   level <= level - CW'(1);
                default: level <= level;
            endcase
        end
    end

    // Sticky error flags for dropped writes and ignored reads
    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en && wr_full)
                overflow <= 1'b1;
            if (rd_en && rd_empty)
                underflow <= 1'b1;
        end
    end

    // First read stage: fetch head word, holds value when no read is accepted
    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            rd_q <= '0;
            rv_q <= 1'b0;
        end else begin
            rv_q <= rd_acc;
            if (rd_acc)
                rd_q <= mem[rptr];
        end
    end

`ifdef WIDTH_CONV_FIFO_OUTREG_EN
    logic [RW-1:0] rd_o;
    logic          rv_o;

    // Extra output register; valid follows the data by one more cycle
    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            rd_o <= '0;
            rv_o <= 1'b0;
        end else begin
            rv_o <= rv_q;
            if (rv_q)
                rd_o <= rd_q;
        end
    end

    assign rd_data  = rd_o;
    assign rd_valid = rv_o;
`else
    assign rd_data  = rd_q;
    assign rd_valid = rv_q;
`endif

endmodule

// File: doc/width_conv_fifo.md
WIDTH_CONV_FIFO -- requirements
Module: width_conv_fifo

Interface
REQ-001 SHALL have parameter WR_DATA_WIDTH, default 16: write word width in bits, range 1..128.
REQ-002 SHALL have parameter RATIO, default 8: write words packed per read word, range 1..16.
REQ-003 SHALL have parameter RD_DEPTH_WIDTH, default 10: storage depth is 2**RD_DEPTH_WIDTH read words, range 2..14.
REQ-004 SHALL have parameter ALMOST_FULL_NUM, default 1016: almost_full threshold, in read words.
REQ-005 SHALL have parameter ALMOST_EMPTY_NUM, default 4: almost_empty threshold, in read words.
REQ-006 SHALL have port clk  input  1: single clock for all logic, rising edge.
REQ-007 SHALL have port tb_rst  input  1: reset, asynchronous, active-high.
REQ-008 SHALL have port wr_en  input  1: write request.
REQ-009 SHALL have port wr_data  input  WR_DATA_WIDTH: write word.
REQ-010 SHALL have port wr_full  output  1: write side cannot accept.
REQ-011 SHALL have port rd_en  input  1: read request.
REQ-012 SHALL have port rd_data  output  WR_DATA_WIDTH*RATIO: read word.
REQ-013 SHALL have port rd_valid  output  1: one-cycle pulse marking rd_data updated.
REQ-014 SHALL have port rd_empty  output  1: no committed read word is stored.
REQ-015 SHALL have port water_level  output  RD_DEPTH_WIDTH+1: count of committed read words.
REQ-016 SHALL have ports almost_full, almost_empty, overflow, underflow  output  1 each.

Function
REQ-017 Write accepted SHALL mean wr_en=1 and wr_full=0; the word SHALL go into packer lane lane_idx, lane 0 = rd_data LSBs.
REQ-018 lane_idx SHALL increment per accepted write; on acceptance at lane RATIO-1, SHALL wrap to 0 and the packed word SHALL be committed to storage at that edge.
REQ-019 wr_full SHALL equal (water_level == 2**RD_DEPTH_WIDTH) AND (lane_idx == RATIO-1); capacity is 2**RD_DEPTH_WIDTH*RATIO + RATIO-1 write words.
REQ-020 A write while wr_full=1 SHALL be dropped, state unchanged, overflow set, even if rd_en=1 in the same cycle.
REQ-021 Read accepted SHALL mean rd_en=1 and rd_empty=0; rd_data SHALL update, and rd_valid SHALL pulse, 1 cycle after acceptance.
REQ-022 rd_data SHALL hold its last value when no read completes.
REQ-023 rd_en while rd_empty=1 SHALL be ignored, underflow set, rd_valid not pulsed; a commit in the same cycle SHALL still proceed.
REQ-024 Commit and read in the same cycle SHALL leave water_level unchanged.
REQ-025 Otherwise water_level SHALL change by +1 per commit and -1 per read.
REQ-026 Storage pointers SHALL wrap modulo 2**RD_DEPTH_WIDTH, with data order preserved (FIFO).
REQ-027 rd_empty SHALL equal (water_level == 0); partially packed words SHALL NOT be readable.
REQ-028 almost_full SHALL be water_level >= ALMOST_FULL_NUM, combinational from the registered count.
REQ-029 almost_empty SHALL be water_level <= ALMOST_EMPTY_NUM, combinational from the registered count.
REQ-030 overflow and underflow SHALL be sticky until reset.

Reset
REQ-031 tb_rst=1 SHALL asynchronously clear pointers, lane_idx, packer, water_level, rd_data, rd_valid, overflow and underflow to 0.
REQ-032 With tb_rst=1, rd_empty=1, wr_full=0, almost_empty=1 and almost_full=0 (with default thresholds).
REQ-033 Reset mid-operation SHALL discard committed and partially packed data.
REQ-034 The first operation SHALL be accepted on the first rising edge after tb_rst falls.

Configuration
REQ-035 Macro WIDTH_CONV_FIFO_OUTREG_EN defined: an extra output register SHALL be inserted, giving read latency 2 cycles, with rd_valid delayed to match.
REQ-036 Macro WIDTH_CONV_FIFO_OUTREG_EN undefined: read latency SHALL be 1 cycle; all other behaviour is identical.

Verification
REQ-037 Reset release -> rd_empty=1, wr_full=0, water_level=0, rd_valid=0, overflow=0, underflow=0.
REQ-038 Defaults, write 0x0001..0x0008, then rd_en -> water_level=1 after 8th write; rd_data=0x0008_0007_0006_0005_0004_0003_0002_0001 with rd_valid 1 cycle after rd_en (2 with macro).
REQ-039 Write 8199 words without reads -> wr_full=1, almost_full=1; 8200th write dropped, overflow=1, water_level=1024.
REQ-040 rd_en while empty -> underflow=1, rd_valid stays 0, rd_data unchanged.
REQ-041 water_level=5, 8th lane write and rd_en in the same cycle -> water_level stays 5; popped word is the oldest stored one.
REQ-042 3 words in packer, assert tb_rst, write 8 new words -> read returns only the 8 new words, lane 0 = first new word.
